instr_word_encoder: RTL and testbench

- Inverse of the control unit's decode path. Takes abstract operation requests (class, register indices, funct3, alternate-op flag, immediate) over a valid/ready handshake.
- Encodes each request into a 32-bit RV32I instruction word, including the funct7 sub/add and sra/srl selection. Writes the words sequentially into instruction memory through a write port with backpressure.
- Used by the test/boot loader to build programs in instruction memory. On request it appends a halt word.

---
 rtl/instr_word_encoder.sv | 183 ++++++++++++++++++
 tb/tb_instr_word_encoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_word_encoder.sv
// ============================================================================
// Module   : instr_word_encoder
// Purpose  : Encodes abstract operation requests into RV32I instruction words
//            and writes them sequentially into instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_word_encoder #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'hBFC00000),
  parameter int                    DEPTH_WORDS = 1024,
  localparam int                   CW          = $clog2(DEPTH_WORDS) + 1
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [2:0]            iOpClass,
  input  logic [4:0]            iRd,
  input  logic [4:0]            iRs1,
  input  logic [4:0]            iRs2,
  input  logic [2:0]            iFunct3,
  input  logic                  iAltOp,
  input  logic [31:0]           iImm,
  input  logic                  iFinish,
  output logic                  oWrEn,
  input  logic                  iWrReady,
  output logic [ADDR_WIDTH-1:0] oWrAddr,
  output logic [31:0]           oWrData,
  output logic [CW-1:0]         oWordCount,
  output logic                  oErr,
  output logic                  oDone
);

  localparam logic [1:0]  c_s_idle  = 2'd0;
  localparam logic [1:0]  c_s_write = 2'd1;
  localparam logic [1:0]  c_s_halt  = 2'd2;
  localparam logic [1:0]  c_s_done  = 2'd3;

  localparam logic [31:0] c_halt_word = 32'h0000006F;
  localparam logic [6:0]  c_f7_alt    = 7'b0100000;

  localparam logic [6:0]  c_op_r      = 7'b0110011;
  localparam logic [6:0]  c_op_i      = 7'b0010011;
  localparam logic [6:0]  c_op_load   = 7'b0000011;
  localparam logic [6:0]  c_op_store  = 7'b0100011;
  localparam logic [6:0]  c_op_branch = 7'b1100011;
  localparam logic [6:0]  c_op_lui    = 7'b0110111;
  localparam logic [6:0]  c_op_jal    = 7'b1101111;

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_data;
  logic [CW-1:0]         r_count;
  logic                  r_err;
  logic                  r_fin;
  logic                  r_run;

  logic [31:0]           w_word;
  logic                  w_illegal;
  logic [6:0]            w_f7;
  logic                  w_full;
  logic                  w_ready;
  logic                  w_wr_en;
  logic                  w_done;
  logic                  w_hs;

  assign w_f7   = iAltOp ? c_f7_alt : 7'b0000000;
  assign w_full = (r_count == CW'(DEPTH_WORDS - 1));
  assign w_hs   = iValid && w_ready;

  always_comb begin
    w_word    = 32'h0;
    w_illegal = 1'b0;
    case (iOpClass)
      3'd0: begin
        w_illegal = iAltOp && !((iFunct3 == 3'b000) || (iFunct3 == 3'b101));
        w_word    = {w_f7, iRs2, iRs1, iFunct3, iRd, c_op_r};
      end
      3'd1: begin
        if ((iFunct3 == 3'b001) || (iFunct3 == 3'b101)) begin
          w_illegal = iAltOp && (iFunct3 == 3'b001);
          w_word    = {w_f7, iImm[4:0], iRs1, iFunct3, iRd, c_op_i};
        end else begin
          w_illegal = iAltOp;
          w_word    = {iImm[11:0], iRs1, iFunct3, iRd, c_op_i};
        end
      end
      3'd2: w_word = {iImm[11:0], iRs1, iFunct3, iRd, c_op_load};
      3'd3: w_word = {iImm[11:5], iRs2, iRs1, iFunct3, iImm[4:0], c_op_store};
      3'd4: begin
        w_illegal = iImm[0];
        w_word    = {iImm[12], iImm[10:5], iRs2, iRs1, iFunct3,
                     iImm[4:1], iImm[11], c_op_branch};
      end
      3'd5: w_word = {iImm[31:12], iRd, c_op_lui};
      3'd6: begin
        w_illegal = iImm[0];
        w_word    = {iImm[20], iImm[10:1], iImm[11], iImm[19:12], iRd, c_op_jal};
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) r_state <= c_s_idle;
    else        r_state <= w_next;
  end

  // An illegal request still completes its handshake; a finish seen alongside it goes straight to HALT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_s_idle: begin
        if (w_hs && !w_illegal) w_next = c_s_write;
        else if (iFinish)       w_next = c_s_halt;
      end
      c_s_write: begin
        if (iWrReady) w_next = (r_fin || iFinish) ? c_s_halt : c_s_idle;
      end
      c_s_halt: begin
        if (iWrReady) w_next = c_s_done;
      end
      default: w_next = c_s_done;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_wr_en = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      c_s_idle:  w_ready = r_run && !w_full;
      c_s_write: w_wr_en = 1'b1;
      c_s_halt:  w_wr_en = 1'b1;
      default:   w_done  = 1'b1;
    endcase
  end

  // r_run keeps oReady low while reset is held and for the first edge after release.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_run   <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_data  <= 32'h0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_fin   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_next == c_s_halt && r_state != c_s_halt) begin
        r_data <= c_halt_word;
      end else if (r_state == c_s_idle && w_hs && !w_illegal) begin
        r_data <= w_word;
      end
      if (r_state == c_s_idle) begin
        r_fin <= w_hs && !w_illegal && iFinish;
        if (w_hs && w_illegal) r_err <= 1'b1;
      end else if (r_state == c_s_write) begin
        r_fin <= r_fin || iFinish;
        if (iWrReady) begin
          r_count <= r_count + CW'(1);
          r_addr  <= r_addr + ADDR_WIDTH'(4);
        end
      end else if (r_state == c_s_halt && iWrReady) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign oReady     = w_ready;
  assign oWrEn      = w_wr_en;
  assign oDone      = w_done;
  assign oWrAddr    = r_addr;
  assign oWrData    = r_data;
  assign oWordCount = r_count;
  assign oErr       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_word_encoder.sv
// ============================================================================
// Module   : tb_instr_word_encoder
// Purpose  : Directed scoreboard bench for instr_word_encoder (DEPTH_WORDS=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_word_encoder;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam int          CW   = 3;

  logic          iClk = 1'b0;
  logic          iRstN;
  logic          iValid;
  logic          oReady;
  logic [2:0]    iOpClass;
  logic [4:0]    iRd, iRs1, iRs2;
  logic [2:0]    iFunct3;
  logic          iAltOp;
  logic [31:0]   iImm;
  logic          iFinish;
  logic          oWrEn;
  logic          iWrReady;
  logic [31:0]   oWrAddr;
  logic [31:0]   oWrData;
  logic [CW-1:0] oWordCount;
  logic          oErr;
  logic          oDone;

  instr_word_encoder #(
    .ADDR_WIDTH  (32),
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (4)
  ) dut (
    .iClk       (iClk),
    .iRstN      (iRstN),
    .iValid     (iValid),
    .oReady     (oReady),
    .iOpClass   (iOpClass),
    .iRd        (iRd),
    .iRs1       (iRs1),
    .iRs2       (iRs2),
    .iFunct3    (iFunct3),
    .iAltOp     (iAltOp),
    .iImm       (iImm),
    .iFinish    (iFinish),
    .oWrEn      (oWrEn),
    .iWrReady   (iWrReady),
    .oWrAddr    (oWrAddr),
    .oWrData    (oWrData),
    .oWordCount (oWordCount),
    .oErr       (oErr),
    .oDone      (oDone)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_addr;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] data, input logic advance);
    sb.push_back('{addr: exp_addr, data: data});
    if (advance) exp_addr = exp_addr + 32'd4;
  endtask

  // Drives one request and holds it until the handshake edge has passed.
  task automatic send(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                      input logic [31:0] imm, input logic fin, input logic wr,
                      input logic [31:0] exp_word);
    int n;
    @(negedge iClk);
    iOpClass = cls; iRd = rd; iRs1 = rs1; iRs2 = rs2;
    iFunct3 = f3; iAltOp = alt; iImm = imm; iValid = 1'b1; iFinish = fin;
    n = 0;
    while (!oReady && n < 20) begin
      @(negedge iClk);
      n++;
    end
    check("hs_ready", oReady, 1);
    if (wr) push(exp_word, 1'b1);
    @(posedge iClk);
    @(negedge iClk);
    iValid = 1'b0; iFinish = 1'b0;
  endtask

  // Waits for a write strobe, compares it with the scoreboard head, lets it be accepted.
  task automatic collect(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!oWrEn && n < 20) begin
      @(negedge iClk);
      n++;
    end
    check({tag, "_wren"}, oWrEn, 1);
    check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_addr"}, oWrAddr, e.addr);
      check({tag, "_data"}, oWrData, e.data);
    end
    @(posedge iClk);
    @(negedge iClk);
  endtask

  task automatic release_reset();
    @(negedge iClk);
    iRstN = 1'b1;
    sb.delete();
    exp_addr = BASE;
    @(negedge iClk);
    @(negedge iClk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRstN = 1'b0; iValid = 1'b0; iFinish = 1'b0; iWrReady = 1'b1;
    iOpClass = '0; iRd = '0; iRs1 = '0; iRs2 = '0; iFunct3 = '0; iAltOp = 1'b0; iImm = '0;
    exp_addr = BASE;
    repeat (3) @(negedge iClk);
    check("rst_ready", oReady, 0);
    check("rst_wren",  oWrEn, 0);
    check("rst_addr",  oWrAddr, BASE);
    check("rst_data",  oWrData, 32'h0);
    check("rst_count", oWordCount, 0);
    check("rst_err",   oErr, 0);
    check("rst_done",  oDone, 0);
    release_reset();
    check("idle_ready", oReady, 1);

    // Fill to the halt slot, then finish.
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h002081B3);
    collect("add");
    check("add_count", oWordCount, 1);
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'h0, 1'b0, 1'b1, 32'h402081B3);
    collect("sub");
    check("sub_count", oWordCount, 2);
    send(3'd1, 5'd5, 5'd6, 5'd0, 3'b101, 1'b1, 32'd3, 1'b0, 1'b1, 32'h40335293);
    collect("srai");
    check("srai_count", oWordCount, 3);
    check("full_ready", oReady, 0);
    iFinish = 1'b1;
    @(negedge iClk);
    iFinish = 1'b0;
    push(32'h0000006F, 1'b0);
    collect("halt_a");
    check("halt_a_count", oWordCount, 4);
    check("halt_a_done",  oDone, 1);
    check("halt_a_ready", oReady, 0);
    check("halt_a_wren",  oWrEn, 0);
    check("halt_a_addr",  oWrAddr, BASE + 32'd12);

    // Backpressure, illegal requests, store/load encodings.
    iRstN = 1'b0;
    release_reset();
    iWrReady = 1'b0;
    send(3'd1, 5'd5, 5'd6, 5'd0, 3'b101, 1'b0, 32'd3, 1'b0, 1'b1, 32'h00335293);
    for (int i = 0; i < 5; i++) begin
      check("bp_wren",  oWrEn, 1);
      check("bp_addr",  oWrAddr, BASE);
      check("bp_data",  oWrData, 32'h00335293);
      check("bp_ready", oReady, 0);
      check("bp_count", oWordCount, 0);
      @(negedge iClk);
    end
    iWrReady = 1'b1;
    collect("srli");
    check("srli_count", oWordCount, 1);

    send(3'd0, 5'd3, 5'd1, 5'd2, 3'b111, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    check("ill_r_err",   oErr, 1);
    check("ill_r_wren",  oWrEn, 0);
    check("ill_r_count", oWordCount, 1);
    check("ill_r_ready", oReady, 1);
    send(3'd7, 5'd1, 5'd1, 5'd1, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("ill_c7_err",   oErr, 1);
    check("ill_c7_wren",  oWrEn, 0);
    check("ill_c7_count", oWordCount, 1);
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd5, 1'b0, 1'b0, 32'h0);
    @(negedge iClk);
    check("ill_br_wren",  oWrEn, 0);
    check("ill_br_count", oWordCount, 1);
    check("ill_br_ready", oReady, 1);

    send(3'd3, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd8, 1'b0, 1'b1, 32'h0020A423);
    collect("sw");
    send(3'd2, 5'd4, 5'd3, 5'd0, 3'b010, 1'b0, 32'hFFFFFFFC, 1'b0, 1'b1, 32'hFFC1A203);
    collect("lw");
    check("lw_count", oWordCount, 3);
    check("b_err_sticky", oErr, 1);

    // Reset while a write is stalled.
    iRstN = 1'b0;
    release_reset();
    check("c_err_cleared", oErr, 0);
    iWrReady = 1'b0;
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd8, 1'b0, 1'b1, 32'h00208463);
    check("beq_wren", oWrEn, 1);
    check("beq_data", oWrData, 32'h00208463);
    #2 iRstN = 1'b0;
    #1;
    check("midrst_wren",  oWrEn, 0);
    check("midrst_count", oWordCount, 0);
    iWrReady = 1'b1;
    release_reset();
    check("midrst_addr",  oWrAddr, BASE);
    check("midrst_ready", oReady, 1);

    send(3'd5, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345000, 1'b0, 1'b1, 32'h123452B7);
    collect("lui");
    send(3'd6, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd16, 1'b0, 1'b1, 32'h010000EF);
    collect("jal_fwd");
    send(3'd6, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'hFFFFFFF8, 1'b1, 1'b1, 32'hFF9FF06F);
    push(32'h0000006F, 1'b0);
    collect("jal_back");
    collect("halt_c");
    check("halt_c_count", oWordCount, 4);
    check("halt_c_done",  oDone, 1);
    check("halt_c_addr",  oWrAddr, BASE + 32'd12);
    repeat (3) @(negedge iClk);
    check("done_hold_wren", oWrEn, 0);
    check("done_hold_done", oDone, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
